// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data RAM between CPU, 4-lane vector and VGA fetch; DMEM_ARB_PERF_EN adds perf counters
module dmem_port_arbiter #(
  parameter int LANES = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_ack,
  input  logic                vec_req,
  input  logic                vec_we,
  input  logic [LANES*AW-1:0] vec_addr,
  input  logic [LANES*DW-1:0] vec_wdata,
  output logic [LANES*DW-1:0] vec_rdata,
  output logic                vec_ack,
  input  logic [AW-1:0]       vga_addr,
  output logic [DW-1:0]       vga_rdata,
  output logic                vga_valid,
  output logic                stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_vga_fetches
`endif
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);
  typedef enum logic [1:0] {GRANT, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {SRC_CPU, SRC_VEC, SRC_VGA} src_t;
  state_t state_q, state_d;
  src_t src_q, src_d, sel_src;
  logic [LW-1:0] lane_q, lane_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d, vga_last_addr_q, vga_last_addr_d, lane_addr;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, cpu_rdata_q, cpu_rdata_d, vga_rdata_q, vga_rdata_d, lane_wdata;
  logic [LANES*DW-1:0] vec_rdata_q, vec_rdata_d;
  logic cpu_ack_q, cpu_ack_d, vec_ack_q, vec_ack_d, vga_valid_q, vga_valid_d;
  logic vga_pend, vec_busy, cpu_new, vec_new, win;
  assign vga_pend = ~vga_valid_q | (vga_addr != vga_last_addr_q);
  assign vec_busy = lane_q != '0;
  assign cpu_new = cpu_req & ~cpu_ack_q;
  assign vec_new = vec_req & ~vec_ack_q;
  assign win = vga_pend | vec_busy | cpu_new | vec_new;
  assign lane_addr = vec_addr[lane_q*AW +: AW];
  assign lane_wdata = vec_wdata[lane_q*DW +: DW];
  assign sel_src = vga_pend ? SRC_VGA : (vec_busy | ~cpu_new) ? SRC_VEC : SRC_CPU;
  // GRANT picks and registers the winning command; WAIT captures read data into the winner's register
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    lane_d = lane_q;
    mem_en_d = 1'b0;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d = 1'b0;
    vec_ack_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vec_rdata_d = vec_rdata_q;
    vga_rdata_d = vga_rdata_q;
    vga_last_addr_d = vga_last_addr_q;
    vga_valid_d = vga_valid_q;
    case (state_q)
      GRANT: begin
        state_d = win ? ISSUE : GRANT;
        src_d = sel_src;
        mem_en_d = win;
        mem_we_d = win & (sel_src == SRC_CPU ? cpu_we : sel_src == SRC_VEC ? vec_we : 1'b0);
        mem_addr_d = sel_src == SRC_VGA ? vga_addr : sel_src == SRC_CPU ? cpu_addr : lane_addr;
        mem_wdata_d = sel_src == SRC_CPU ? cpu_wdata : lane_wdata;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = GRANT;
        if (src_q == SRC_VGA) begin
          vga_rdata_d = mem_rdata;
          vga_last_addr_d = mem_addr_q;
          vga_valid_d = 1'b1;
        end else if (src_q == SRC_CPU) begin
          cpu_ack_d = 1'b1;
          cpu_rdata_d = mem_we_q ? cpu_rdata_q : mem_rdata;
        end else begin
          if (!mem_we_q) vec_rdata_d[lane_q*DW +: DW] = mem_rdata;
          lane_d = (lane_q == LAST) ? '0 : lane_q + 1'b1;
          vec_ack_d = lane_q == LAST;
        end
      end
      default: state_d = GRANT;
    endcase
  end
  // state and datapath registers; reset abandons any in-flight beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GRANT;
      src_q <= SRC_CPU;
      lane_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q <= 1'b0;
      vec_ack_q <= 1'b0;
      cpu_rdata_q <= '0;
      vec_rdata_q <= '0;
      vga_rdata_q <= '0;
      vga_last_addr_q <= '0;
      vga_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      lane_q <= lane_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q <= cpu_ack_d;
      vec_ack_q <= vec_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vec_rdata_q <= vec_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      vga_last_addr_q <= vga_last_addr_d;
      vga_valid_q <= vga_valid_d;
    end
  end
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack = cpu_ack_q;
  assign vec_rdata = vec_rdata_q;
  assign vec_ack = vec_ack_q;
  assign vga_rdata = vga_rdata_q;
  assign vga_valid = vga_valid_q & (vga_addr == vga_last_addr_q);
  assign stall = (cpu_req & ~cpu_ack_q) | (vec_req & ~vec_ack_q);
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_vga_q, perf_vga_d;
  // saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall & ~&perf_stall_q};
    perf_vga_d = perf_vga_q + {31'd0, (state_q == GRANT) & vga_pend & ~&perf_vga_q};
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_vga_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_vga_q <= perf_vga_d;
    end
  end
  assign perf_stall_cycles = perf_stall_q;
  assign perf_vga_fetches = perf_vga_q;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized self-checking bench with a memory model and expected-contents reference
module tb_dmem_port_arbiter;
  localparam int LANES = 4, AW = 32, DW = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, cpu_rdata;
  logic vec_req = 1'b0, vec_we = 1'b0, vec_ack;
  logic [LANES*AW-1:0] vec_addr = '0;
  logic [LANES*DW-1:0] vec_wdata = '0, vec_rdata, exp_vec = '0;
  logic [AW-1:0] vga_addr = '0, mem_addr;
  logic [DW-1:0] vga_rdata, mem_wdata, mem_rdata = '0;
  logic vga_valid, stall, mem_en, mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_vga_fetches;
`endif
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic pre_we = 1'b0;
  logic [9:0] pre_idx = '0;
  logic [DW-1:0] pre_data = '0;
  int errors = 0, checks = 0;

  dmem_port_arbiter #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vec_req(vec_req), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .vec_rdata(vec_rdata), .vec_ack(vec_ack),
    .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_valid(vga_valid), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_vga_fetches(perf_vga_fetches)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_idx = a[11:2];
    pre_data = d;
    ref_mem[a[11:2]] = d;
    tick();
    pre_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int hi);
    logic [9:0] w;
    w = 10'($urandom_range(1, hi));
    return {20'd0, w, 2'b00};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) poke(32'(i * 4), $urandom);
    poke(32'h0, 32'hA5);
    @(negedge clk);
    checks += 5;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
    if (vga_valid !== 1'b0) begin errors++; $display("FAIL reset_vga_valid got=%0b exp=0", vga_valid); end
    if ({cpu_ack, vec_ack, stall} !== 3'b000) begin errors++; $display("FAIL reset_acks got=%b exp=000", {cpu_ack, vec_ack, stall}); end
    if (vga_rdata !== '0 || cpu_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", vga_rdata, cpu_rdata); end
    if (vec_rdata !== '0) begin errors++; $display("FAIL reset_vec_rdata got=%h exp=0", vec_rdata); end
    tick();
    reset = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1)) begin errors++; $display("FAIL vga_first_mem_en c=%0d got=%0b", c, mem_en); end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL vga_first_addr got=%h we=%0b exp=0", mem_addr, mem_we); end
      end
      if (c == 2) begin
        checks++;
        if (vga_valid !== 1'b0) begin errors++; $display("FAIL vga_early_valid got=%0b exp=0", vga_valid); end
      end
      if (c == 3) begin
        checks++;
        if (vga_valid !== 1'b1 || vga_rdata !== 32'hA5) begin errors++; $display("FAIL vga_first_data got=%h v=%0b exp=a5", vga_rdata, vga_valid); end
      end
      tick();
    end
  endtask

  task automatic test_scalar();
    logic [31:0] a, d;
    logic we;
    a = '0;
    for (int k = 0; k < 7; k++) begin
      we = (k % 2 == 1);
      if (k == 0) begin a = 32'h40; poke(a, 32'h1234); end
      else if (we) a = rand_addr(1023);
      d = $urandom;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        checks += 3;
        if (stall !== (c < 3)) begin errors++; $display("FAIL scalar_stall k=%0d c=%0d got=%0b", k, c, stall); end
        if (cpu_ack !== (c == 3)) begin errors++; $display("FAIL scalar_ack k=%0d c=%0d got=%0b", k, c, cpu_ack); end
        if (mem_en !== (c == 1)) begin errors++; $display("FAIL scalar_mem_en k=%0d c=%0d got=%0b", k, c, mem_en); end
        if (c == 1) begin
          checks++;
          if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== d)) begin errors++; $display("FAIL scalar_cmd k=%0d got we=%0b a=%h d=%h exp we=%0b a=%h d=%h", k, mem_we, mem_addr, mem_wdata, we, a, d); end
        end
        if (c == 3 && !we) begin
          checks++;
          if (cpu_rdata !== ref_mem[a[11:2]]) begin errors++; $display("FAIL scalar_rdata k=%0d got=%h exp=%h", k, cpu_rdata, ref_mem[a[11:2]]); end
        end
        tick();
      end
      if (we) ref_mem[a[11:2]] = d;
      cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_vec_store();
    vec_req = 1'b1; vec_we = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      vec_addr[l*AW +: AW] = 32'h10 + 32'(4 * l);
      vec_wdata[l*DW +: DW] = 32'(l + 1);
    end
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      checks += 3;
      if (mem_en !== (c % 3 == 1 && c < 12)) begin errors++; $display("FAIL vst_mem_en c=%0d got=%0b", c, mem_en); end
      if (vec_ack !== (c == 12)) begin errors++; $display("FAIL vst_ack c=%0d got=%0b", c, vec_ack); end
      if (stall !== (c < 12)) begin errors++; $display("FAIL vst_stall c=%0d got=%0b", c, stall); end
      if (c % 3 == 1 && c < 12) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h10 + 32'(4 * (c / 3)) || mem_wdata !== 32'(c / 3 + 1)) begin errors++; $display("FAIL vst_cmd c=%0d got we=%0b a=%h d=%h", c, mem_we, mem_addr, mem_wdata); end
      end
      if (c == 12) begin
        checks++;
        if (vec_rdata !== exp_vec) begin errors++; $display("FAIL vst_rdata_hold got=%h exp=%h", vec_rdata, exp_vec); end
      end
      tick();
    end
    for (int l = 0; l < LANES; l++) ref_mem[4 + l] = 32'(l + 1);
    vec_req = 1'b0;
    tick();
  endtask

  task automatic test_vec_load_vga();
    logic [31:0] vd;
    vd = $urandom;
    poke(32'h200, vd);
    vec_req = 1'b1; vec_we = 1'b0;
    for (int l = 0; l < LANES; l++) vec_addr[l*AW +: AW] = 32'h1C - 32'(4 * l);
    for (int l = 0; l < LANES; l++) exp_vec[l*DW +: DW] = ref_mem[vec_addr[l*AW + 2 +: 10]];
    for (int c = 0; c <= 15; c++) begin
      if (c == 4) vga_addr = 32'h200;
      @(negedge clk);
      checks += 3;
      if (mem_en !== (c % 3 == 1 && c < 15)) begin errors++; $display("FAIL vld_mem_en c=%0d got=%0b", c, mem_en); end
      if (vec_ack !== (c == 15)) begin errors++; $display("FAIL vld_ack c=%0d got=%0b", c, vec_ack); end
      if (stall !== (c < 15)) begin errors++; $display("FAIL vld_stall c=%0d got=%0b", c, stall); end
      if (c == 5) begin
        checks++;
        if (vga_valid !== 1'b0) begin errors++; $display("FAIL vga_stale_valid got=%0b exp=0", vga_valid); end
      end
      if (c == 7) begin
        checks++;
        if (mem_addr !== 32'h200 || mem_we !== 1'b0) begin errors++; $display("FAIL vga_insert_addr got=%h exp=200", mem_addr); end
      end
      if (c == 9) begin
        checks++;
        if (vga_valid !== 1'b1 || vga_rdata !== vd) begin errors++; $display("FAIL vga_insert_data got=%h v=%0b exp=%h", vga_rdata, vga_valid, vd); end
      end
      if (c == 15) begin
        checks++;
        if (vec_rdata !== exp_vec) begin errors++; $display("FAIL vld_rdata got=%h exp=%h", vec_rdata, exp_vec); end
      end
      tick();
    end
    vec_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] ca;
    ca = rand_addr(1023);
    poke(ca, $urandom);
    for (int l = 0; l < LANES; l++) begin
      vec_addr[l*AW +: AW] = rand_addr(1023);
      poke(vec_addr[l*AW +: AW], $urandom);
    end
    for (int l = 0; l < LANES; l++) exp_vec[l*DW +: DW] = ref_mem[vec_addr[l*AW + 2 +: 10]];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    vec_req = 1'b1; vec_we = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      if (c == 4) cpu_req = 1'b0;
      @(negedge clk);
      checks += 4;
      if (cpu_ack !== (c == 3)) begin errors++; $display("FAIL cont_cpu_ack c=%0d got=%0b", c, cpu_ack); end
      if (vec_ack !== (c == 15)) begin errors++; $display("FAIL cont_vec_ack c=%0d got=%0b", c, vec_ack); end
      if (mem_en !== (c % 3 == 1 && c < 15)) begin errors++; $display("FAIL cont_mem_en c=%0d got=%0b", c, mem_en); end
      if (stall !== (c < 15)) begin errors++; $display("FAIL cont_stall c=%0d got=%0b", c, stall); end
      if (c == 1 || c == 4) begin
        checks++;
        if (mem_addr !== (c == 1 ? ca : vec_addr[AW-1:0])) begin errors++; $display("FAIL cont_order c=%0d got=%h exp=%h", c, mem_addr, c == 1 ? ca : vec_addr[AW-1:0]); end
      end
      if (c == 3) begin
        checks++;
        if (cpu_rdata !== ref_mem[ca[11:2]]) begin errors++; $display("FAIL cont_cpu_rdata got=%h exp=%h", cpu_rdata, ref_mem[ca[11:2]]); end
      end
      if (c == 15) begin
        checks++;
        if (vec_rdata !== exp_vec) begin errors++; $display("FAIL cont_vec_rdata got=%h exp=%h", vec_rdata, exp_vec); end
      end
      tick();
    end
    vec_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFC; cpu_wdata = $urandom;
    for (int c = 0; c <= 3; c++) begin
      if (c == 1) reset = 1'b1;
      if (c == 2) cpu_req = 1'b0;
      if (c == 3) reset = 1'b0;
      @(negedge clk);
      if (c >= 1) begin
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack c=%0d got=%0b exp=0", c, cpu_ack); end
      end
      if (c == 2) begin
        checks++;
        if (mem_en !== 1'b0 || vga_valid !== 1'b0) begin errors++; $display("FAIL rstmid_clear mem_en=%0b vga_valid=%0b exp=0", mem_en, vga_valid); end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    a = rand_addr(1000);
    poke(a, $urandom);
    @(negedge clk);
    checks++;
    if (vga_valid !== 1'b1) begin errors++; $display("FAIL rstmid_vga_refetch got=%0b exp=1", vga_valid); end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checks += 2;
      if (cpu_ack !== (c == 3)) begin errors++; $display("FAIL rstmid_fresh_ack c=%0d got=%0b", c, cpu_ack); end
      if (mem_en !== (c == 1)) begin errors++; $display("FAIL rstmid_fresh_en c=%0d got=%0b", c, mem_en); end
      if (c == 3) begin
        checks++;
        if (cpu_rdata !== ref_mem[a[11:2]]) begin errors++; $display("FAIL rstmid_fresh_rdata got=%h exp=%h", cpu_rdata, ref_mem[a[11:2]]); end
      end
      tick();
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_random_mix();
    int op, exp;
    logic [31:0] a;
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 3);
      exp = (op < 2) ? 3 : 3 * LANES;
      a = rand_addr(63);
      cpu_addr = a; cpu_we = (op == 1); cpu_wdata = $urandom; cpu_req = (op < 2);
      for (int l = 0; l < LANES; l++) begin
        vec_addr[l*AW +: AW] = rand_addr(63);
        vec_wdata[l*DW +: DW] = $urandom;
      end
      vec_we = (op == 3); vec_req = (op >= 2);
      if (op == 2) for (int l = 0; l < LANES; l++) exp_vec[l*DW +: DW] = ref_mem[vec_addr[l*AW + 2 +: 10]];
      for (int c = 0; c <= exp; c++) begin
        @(negedge clk);
        checks += 2;
        if ((op < 2 ? cpu_ack : vec_ack) !== (c == exp)) begin errors++; $display("FAIL mix_ack k=%0d op=%0d c=%0d got=%0b", k, op, c, op < 2 ? cpu_ack : vec_ack); end
        if (stall !== (c < exp)) begin errors++; $display("FAIL mix_stall k=%0d c=%0d got=%0b", k, c, stall); end
        if (c == exp && op == 0) begin
          checks++;
          if (cpu_rdata !== ref_mem[a[11:2]]) begin errors++; $display("FAIL mix_cpu_rdata k=%0d got=%h exp=%h", k, cpu_rdata, ref_mem[a[11:2]]); end
        end
        if (c == exp && op >= 2) begin
          checks++;
          if (vec_rdata !== exp_vec) begin errors++; $display("FAIL mix_vec_rdata k=%0d got=%h exp=%h", k, vec_rdata, exp_vec); end
        end
        tick();
      end
      if (op == 1) ref_mem[a[11:2]] = cpu_wdata;
      if (op == 3) for (int l = 0; l < LANES; l++) ref_mem[vec_addr[l*AW + 2 +: 10]] = vec_wdata[l*DW +: DW];
      cpu_req = 1'b0; vec_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 2; i++) tick();
    test_scalar();
    test_vec_store();
    test_vec_load_vga();
    test_contention();
    test_random_mix();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
